// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite pixel pipeline.
package sprite_pkg;

  localparam int COORD_W = 10;
  localparam int DATA_W  = 12;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  localparam logic [DATA_W-1:0] TRANSPARENT = 12'hF0F;

  typedef logic [DATA_W-1:0] rgb_t;

endpackage

// File: rtl/sprite_fetch_if.sv
// Read bus between the sprite fetch stage and the synchronous sprite ROM.
// The ROM returns rom_data one clock after it samples rom_addr.
interface sprite_fetch_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 12
);

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);

endinterface

// File: rtl/sprite_fetch_anim_ctrl.sv
// Animation frame counter: advances anim_frame once every FRAME_DIV
// enabled video frames and wraps after the last stored sprite frame.
module anim_ctrl #(
  parameter int FRAMES    = 4,
  parameter int FRAME_DIV = 8,
  localparam int FW = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          anim_en,
  output logic [FW-1:0] anim_frame
);

  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(FRAME_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES - 1);

  logic [DW-1:0] div_cnt;

  // Count enabled frame_start pulses; step the frame index when the divider wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt    <= '0;
      anim_frame <= '0;
    end else if (frame_start && anim_en) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt    <= '0;
        anim_frame <= (anim_frame == FRAME_LAST) ? '0 : anim_frame + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_fetch.sv
// Sprite fetch stage: maps the scan position onto sprite ROM addresses,
// tracks the ROM's one-cycle latency and applies colour-key transparency.
// Three-stage pipeline: address register, ROM register, output register.
// SPR_W, SPR_H and FRAMES are expected to be powers of two so the ROM
// address is a plain concatenation {frame, row, column}.
module sprite_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 32,
  parameter int FRAMES    = 4,
  parameter int FRAME_DIV = 8,
  parameter int DATA_W    = sprite_pkg::DATA_W,
  parameter int COORD_W   = sprite_pkg::COORD_W,
  parameter logic [DATA_W-1:0] TRANSPARENT = sprite_pkg::TRANSPARENT,
  localparam int ADDRW = $clog2(SPR_W * SPR_H * FRAMES),
  localparam int FW    = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [COORD_W-1:0] spr_x,
  input  logic [COORD_W-1:0] spr_y,
  input  logic               anim_en,
  sprite_fetch_if.master     rom,
  output logic [DATA_W-1:0]  rgb_out,
  output logic               rgb_valid,
  output logic               pix_valid_out,
  output logic [FW-1:0]      anim_frame
);

  localparam int XB = $clog2(SPR_W);
  localparam int YB = $clog2(SPR_H);

  localparam logic signed [COORD_W:0] SPR_W_S = (COORD_W + 1)'(SPR_W);
  localparam logic signed [COORD_W:0] SPR_H_S = (COORD_W + 1)'(SPR_H);

  // Sprite position as seen by the current video frame.
  logic [COORD_W-1:0] sx_q;
  logic [COORD_W-1:0] sy_q;

  // Stage 1 combinational results.
  logic signed [COORD_W:0] rel_x;
  logic signed [COORD_W:0] rel_y;
  logic                    in_x;
  logic                    in_y;
  logic                    hit_c;
  logic [ADDRW-1:0]        addr_c;

  // Pipeline registers.
  logic [ADDRW-1:0] rom_addr_q;
  logic             hit1;
  logic             pv1;
  logic             hit2;
  logic             pv2;
  logic             opaque_c;

  anim_ctrl #(
    .FRAMES    (FRAMES),
    .FRAME_DIV (FRAME_DIV)
  ) u_anim (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .anim_en     (anim_en),
    .anim_frame  (anim_frame)
  );

  // Latch the requested sprite position only at frame start so it cannot tear mid-frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx_q <= '0;
      sy_q <= '0;
    end else if (frame_start) begin
      sx_q <= spr_x;
      sy_q <= spr_y;
    end
  end

  // Sprite-relative coordinates, hit test with right/bottom clipping, and ROM address.
  always_comb begin
    rel_x  = $signed({1'b0, pix_x}) - $signed({1'b0, sx_q});
    rel_y  = $signed({1'b0, pix_y}) - $signed({1'b0, sy_q});
    in_x   = !rel_x[COORD_W] && (rel_x < SPR_W_S);
    in_y   = !rel_y[COORD_W] && (rel_y < SPR_H_S);
    hit_c  = pix_valid && in_x && in_y;
    addr_c = '0;
    if (hit_c) begin
      addr_c = {anim_frame, rel_y[YB-1:0], rel_x[XB-1:0]};
    end
  end

  // Stage 1: register the ROM address together with its hit and scan-valid flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      hit1       <= 1'b0;
      pv1        <= 1'b0;
    end else begin
      rom_addr_q <= addr_c;
      hit1       <= hit_c;
      pv1        <= pix_valid;
    end
  end

  assign rom.rom_addr = rom_addr_q;

  // Stage 2: carry the flags alongside the ROM's internal read register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit2 <= 1'b0;
      pv2  <= 1'b0;
    end else begin
      hit2 <= hit1;
      pv2  <= pv1;
    end
  end

  // A pixel is drawn only inside the sprite and when it is not the colour key.
  always_comb begin
    opaque_c = hit2 && (rom.rom_data != TRANSPARENT);
  end

  // Stage 3: output register feeding the display mux.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out       <= '0;
      rgb_valid     <= 1'b0;
      pix_valid_out <= 1'b0;
    end else begin
      rgb_out       <= opaque_c ? rom.rom_data : '0;
      rgb_valid     <= opaque_c;
      pix_valid_out <= pv2;
    end
  end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Pixel-pipeline stage that sits directly upstream of the sprite block ROM.
- Converts the VGA scan position (pix_x, pix_y) and a per-frame sprite position into ROM addresses.
- Aligns its hit/valid flags with the ROM's 1-cycle read latency and applies colour-key transparency.
- Outputs one RGB pixel per clock to the display mux. It also owns the sprite animation frame counter.

Parameters:
- SPR_W, 32: sprite width in pixels (power of two).
- SPR_H, 32: sprite height in pixels.
- FRAMES, 4: animation frames stored back-to-back in the ROM (power of two).
- FRAME_DIV, 8: video frames per animation step.
- DATA_W, 12: ROM word / RGB444 width.
- COORD_W, 10: pixel coordinate width.
- TRANSPARENT, 12'hF0F: colour-key value, never drawn.
- ADDRW, $clog2(SPR_W*SPR_H*FRAMES): ROM address width (localparam).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- pix_x  in  COORD_W  current scan column
- pix_y  in  COORD_W  current scan row
- pix_valid  in  1  scan position is inside the active video area
- frame_start  in  1  one-cycle pulse at start of each video frame
- spr_x  in  COORD_W  requested sprite top-left column
- spr_y  in  COORD_W  requested sprite top-left row
- anim_en  in  1  enable animation stepping
- rom_addr  out  ADDRW  address to sprite ROM
- rom_data  in  DATA_W  ROM read data, valid 1 cycle after rom_addr
- rgb_out  out  DATA_W  pixel colour
- rgb_valid  out  1  sprite pixel is opaque at this position
- pix_valid_out  out  1  pix_valid delayed to match rgb_out
- anim_frame  out  $clog2(FRAMES)  current animation frame index

Behaviour:
- Reset (async, immediate):
  - rom_addr, rgb_out, rgb_valid, pix_valid_out, anim_frame = 0.
  - Shadow position registers and divider counter = 0.
  - All pipeline hit/valid flags are cleared, including mid-frame.
- Position shadowing:
  - On a clk edge with frame_start=1, spr_x and spr_y are latched into shadow registers.
  - All hit math uses the shadow registers only, which prevents mid-frame tearing.
  - The pixel sampled on the same edge uses the old shadow values.
- Stage 1, registered on the edge that samples the inputs:
  - rel_x = pix_x - sx_q and rel_y = pix_y - sy_q, computed at COORD_W+1 bits signed.
  - hit1 = pix_valid && 0 <= rel_x < SPR_W && 0 <= rel_y < SPR_H. There is no wrap-around: a sprite overlapping the right/bottom edge is clipped.
  - rom_addr = anim_frame*SPR_W*SPR_H + rel_y*SPR_W + rel_x when hit1, else 0. Implemented as a concatenation, no multiplier.
  - pv1 = pix_valid.
- Stage 2 is the ROM's own register: hit2 <= hit1, pv2 <= pv1.
- Stage 3, output register:
  - rgb_valid <= hit2 && rom_data != TRANSPARENT.
  - rgb_out <= rom_data when that condition holds, else 0.
  - pix_valid_out <= pv2.
- Latency: outputs reflect the inputs sampled exactly 3 edges earlier. Throughput is 1 pixel per clock, with no stalls.
- Animation divider:
  - On frame_start with anim_en=1, div_cnt increments.
  - At FRAME_DIV-1, div_cnt wraps to 0 and anim_frame increments modulo FRAMES, wrapping FRAMES-1 to 0.
  - With anim_en=0, div_cnt and anim_frame hold.
  - A new anim_frame value applies to pixels sampled after the updating edge.
- pix_valid=0 forces hit1=0 regardless of coordinates.

Decomposition:
- Shared package sprite_pkg holds:
  - DATA_W, TRANSPARENT
  - screen dimensions (640x480)
  - COORD_W
  - rgb_t typedef (DATA_W bits)
- Sub-module anim_ctrl contains the FRAME_DIV divider and anim_frame counter. Ports: clk, rst, frame_start, anim_en, anim_frame.
- The bench instantiates sprite_fetch with the existing ROM, loaded from a test hex file where word[i] = i[11:0], except word 5 = 12'hF0F.

Test Plan:
- Reset: assert rst asynchronously mid-stream between edges → rgb_valid=0, rom_addr=0, anim_frame=0, pix_valid_out=0 immediately, without waiting for a clock edge.
- Position latch and latency:
  - Drive spr_x=100, spr_y=50 with a frame_start pulse.
  - Present pix (100,50), pix_valid=1 → rom_addr=0 after 1 edge; rgb_out=12'h000 and rgb_valid=1 on the 3rd edge.
  - Present pix (101,50) → rgb_out=12'h001.
- Bounds: pix (131,81) → rom_addr=1023, rgb_out=12'h3FF. Pix (132,50) and (99,50) → rgb_valid=0, rom_addr=0.
- Transparency: pix (105,50) → addr 5, rgb_valid=0, rgb_out=0, pix_valid_out=1.
- Animation:
  - anim_en=1, 8 frame_start pulses → anim_frame=1; pix (100,50) → rom_addr=1024.
  - After 32 pulses total → anim_frame=0.
  - With anim_en=0 over 20 pulses → anim_frame unchanged.
- Clipping and shadowing:
  - Set spr_x=620 with frame_start → pix_x 620..639 hit; pix_x 0..11 on the same rows do not hit.
  - Change spr_x mid-frame without frame_start → hit region unchanged until the next frame_start.
